// File: rtl/zoctal_mr_readback_checker.sv
// ---------------------------------------------------------------------------
// ZoctalMrReadbackChecker
//
// Purpose:
//   After power-up configuration, walks the Octal RAM mode-register table and
//   verifies it. The write entries (indices 0..WR_CNT-1) are first copied into
//   a small shadow store. Each read entry (indices WR_CNT..WR_CNT+RD_CNT-1) is
//   then issued as a Mode Register Read through the command engine, and the
//   returned byte is compared against the shadow copy for that MR address.
//   Pass/fail, the first failing index and a saturating error count are
//   reported once the walk completes.
//
// Ports:
//   iClk, iRst_N        clock, synchronous active-low reset
//   iStart              one-cycle start pulse (ignored while oBusy)
//   oNo                 table index presented to the config table
//   iRegAddr, iRegData  table entry for oNo (combinational lookup)
//   oMrrReq, oMrrAddr   MRR request and MR address to the command engine
//   iMrrAck             engine accepted the request
//   iMrrValid, iMrrData one-cycle read data return
//   oBusy, oDone        run in progress / one-cycle completion pulse
//   oPass, oFailIdx,    result of the last run, held until the next start
//   oErrCnt
// ---------------------------------------------------------------------------
module zoctal_mr_readback_checker #(
   parameter int         WR_CNT      = 4,
   parameter int         RD_CNT      = 6,
   parameter int         TIMEOUT_CYC = 1023,
   parameter logic [7:0] MR8_MASK    = 8'hCF
) (
   input  logic       iClk,
   input  logic       iRst_N,
   input  logic       iStart,
   output logic [7:0] oNo,
   input  logic [7:0] iRegAddr,
   input  logic [7:0] iRegData,
   output logic       oMrrReq,
   output logic [7:0] oMrrAddr,
   input  logic       iMrrAck,
   input  logic       iMrrValid,
   input  logic [7:0] iMrrData,
   output logic       oBusy,
   output logic       oDone,
   output logic       oPass,
   output logic [7:0] oFailIdx,
   output logic [3:0] oErrCnt
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      REQ,
      WAIT,
      CMP,
      DONE
   } stateT;

   stateT             state;
   stateT             nextState;

   logic [7:0]        noReg;
   logic [3:0]        errCnt;
   logic [7:0]        failIdx;
   logic              passReg;
   logic [7:0]        rdData;
   logic [TMO_W-1:0]  tmoCnt;

   logic [7:0]        shadowAddr [WR_CNT];
   logic [7:0]        shadowData [WR_CNT];
   logic [WR_CNT-1:0] shadowVld;

   logic              loadLast;
   logic              lastEntry;
   logic              tmoHit;
   logic              capture;
   logic              ackOnly;
   logic              tmoFire;
   logic              shHit;
   logic [7:0]        shVal;
   logic [7:0]        cmpMask;
   logic              cmpFail;
   logic              logErr;
   logic              advance;

   // Shadow lookup for the MR address of the entry being compared. Scanning
   // upward and letting later matches overwrite earlier ones means that when
   // the table writes the same MR twice, the last (highest index) write is
   // the value the device should actually hold.
   always_comb begin
      shHit = 1'b0;
      shVal = 8'h00;
      for (int i = 0; i < WR_CNT; i++) begin
         if (shadowVld[i] && (shadowAddr[i] == iRegAddr)) begin
            shHit = 1'b1;
            shVal = shadowData[i];
         end
      end
   end

   // Per-cycle decode of the handshake and compare events. Returned data wins
   // over a timeout landing in the same cycle, and an ack alone also holds the
   // timeout off for that cycle since the engine has just made progress. MR8
   // has reserved bits OP5:OP4 that read back undefined, so they are masked.
   always_comb begin
      loadLast  = (noReg == 8'(WR_CNT - 1));
      lastEntry = (noReg == 8'(WR_CNT + RD_CNT - 1));
      tmoHit    = (tmoCnt == TMO_W'(TIMEOUT_CYC));
      capture   = ((state == REQ) && iMrrAck && iMrrValid) ||
                  ((state == WAIT) && iMrrValid);
      ackOnly   = (state == REQ) && iMrrAck && !iMrrValid;
      tmoFire   = ((state == REQ) || (state == WAIT)) && tmoHit &&
                  !capture && !ackOnly;
      cmpMask   = (iRegAddr == 8'h08) ? MR8_MASK : 8'hFF;
      cmpFail   = (state == CMP) && shHit && (((rdData ^ shVal) & cmpMask) != 8'h00);
      logErr    = tmoFire || cmpFail;
      advance   = (tmoFire || (state == CMP)) && !lastEntry;
   end

   // State register. Reset is synchronous, so an abort mid-run simply lands
   // back in IDLE on the next edge without ever visiting DONE.
   always_ff @(posedge iClk) begin
      if (!iRst_N) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A timeout on the final entry finishes the run just as
   // a compare of the final entry does; otherwise the walk moves on to the
   // next read entry.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (iStart) begin
               nextState = LOAD;
            end
         end
         LOAD: begin
            if (loadLast) begin
               nextState = REQ;
            end
         end
         REQ: begin
            if (capture) begin
               nextState = CMP;
            end else if (ackOnly) begin
               nextState = WAIT;
            end else if (tmoFire) begin
               nextState = lastEntry ? DONE : REQ;
            end
         end
         WAIT: begin
            if (capture) begin
               nextState = CMP;
            end else if (tmoFire) begin
               nextState = lastEntry ? DONE : REQ;
            end
         end
         CMP: begin
            nextState = lastEntry ? DONE : REQ;
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath: table index, shadow load, read capture, timeout counter and
   // the result registers. The timeout counter restarts whenever a fresh REQ
   // begins, including the REQ-to-REQ hop after a timeout, and keeps counting
   // through WAIT so a missing ack and a missing read both end up here.
   always_ff @(posedge iClk) begin
      if (!iRst_N) begin
         noReg     <= 8'h00;
         errCnt    <= 4'h0;
         failIdx   <= 8'hFF;
         passReg   <= 1'b0;
         rdData    <= 8'h00;
         tmoCnt    <= '0;
         shadowVld <= '0;
      end else begin
         if ((state == IDLE) && iStart) begin
            noReg     <= 8'h00;
            errCnt    <= 4'h0;
            failIdx   <= 8'hFF;
            passReg   <= 1'b0;
            shadowVld <= '0;
         end

         if (state == LOAD) begin
            for (int i = 0; i < WR_CNT; i++) begin
               if (noReg == 8'(i)) begin
                  shadowAddr[i] <= iRegAddr;
                  shadowData[i] <= iRegData;
                  shadowVld[i]  <= 1'b1;
               end
            end
            noReg <= noReg + 8'd1;
         end

         if (capture) begin
            rdData <= iMrrData;
         end

         if (logErr) begin
            if (errCnt != 4'hF) begin
               errCnt <= errCnt + 4'd1;
            end
            if (failIdx == 8'hFF) begin
               failIdx <= noReg;
            end
         end

         if (advance) begin
            noReg <= noReg + 8'd1;
         end

         if ((nextState == REQ) && ((state != REQ) || tmoFire)) begin
            tmoCnt <= '0;
         end else if ((state == REQ) || (state == WAIT)) begin
            tmoCnt <= tmoCnt + TMO_W'(1);
         end

         if (state == DONE) begin
            passReg <= (errCnt == 4'h0);
         end
      end
   end

   // Outputs. The request is gated by reset directly so an abort withdraws it
   // in the same cycle rather than waiting for the state register. oPass is
   // already valid during the oDone cycle because the error count is final by
   // the time DONE is entered.
   always_comb begin
      oNo      = noReg;
      oMrrReq  = (state == REQ) && iRst_N;
      oMrrAddr = oMrrReq ? iRegAddr : 8'h00;
      oBusy    = (state == LOAD) || (state == REQ) || (state == WAIT) || (state == CMP);
      oDone    = (state == DONE);
      oPass    = (state == DONE) ? (errCnt == 4'h0) : passReg;
      oFailIdx = failIdx;
      oErrCnt  = errCnt;
   end

endmodule

// File: tb/tb_zoctal_mr_readback_checker.sv
// ---------------------------------------------------------------------------
// tb_zoctal_mr_readback_checker
//
// Purpose:
//   Directed self-checking bench for the mode-register readback checker. A
//   small combinational config table answers oNo lookups, and the main
//   initial block plays the command engine one read entry at a time with
//   per-entry ack delays, response modes and read data.
//
// Table used throughout:
//   0: MR00 <- 18   1: MR04 <- 40   2: MR08 <- 00   3: MR00 <- 08 (overrides 0)
//   4: read MR04    5: read MR01    6: read MR00    7: read MR02
//   8: read MR03    9: read MR08
// ---------------------------------------------------------------------------
module tb_zoctal_mr_readback_checker;

   logic       clk;
   logic       rstN;
   logic       start;
   logic [7:0] no;
   logic [7:0] regAddr;
   logic [7:0] regData;
   logic       mrrReq;
   logic [7:0] mrrAddr;
   logic       mrrAck;
   logic       mrrValid;
   logic [7:0] mrrData;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] failIdx;
   logic [3:0] errCnt;

   int         checks = 0;
   int         errors = 0;

   logic [7:0] respData [10];
   int         ackDly   [10];
   int         respMode [10];

   zoctal_mr_readback_checker dut (
      .iClk      (clk),
      .iRst_N    (rstN),
      .iStart    (start),
      .oNo       (no),
      .iRegAddr  (regAddr),
      .iRegData  (regData),
      .oMrrReq   (mrrReq),
      .oMrrAddr  (mrrAddr),
      .iMrrAck   (mrrAck),
      .iMrrValid (mrrValid),
      .iMrrData  (mrrData),
      .oBusy     (busy),
      .oDone     (done),
      .oPass     (pass),
      .oFailIdx  (failIdx),
      .oErrCnt   (errCnt)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] tableAddr(input int idx);
      case (idx)
         0: return 8'h00;
         1: return 8'h04;
         2: return 8'h08;
         3: return 8'h00;
         4: return 8'h04;
         5: return 8'h01;
         6: return 8'h00;
         7: return 8'h02;
         8: return 8'h03;
         9: return 8'h08;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] tableData(input int idx);
      case (idx)
         0: return 8'h18;
         1: return 8'h40;
         2: return 8'h00;
         3: return 8'h08;
         default: return 8'h00;
      endcase
   endfunction

   // Config table: answers the DUT's index combinationally, as the real
   // table ROM would.
   always_comb begin
      regAddr = tableAddr(int'(no));
      regData = tableData(int'(no));
   end

   // Safety net so the bench always ends even if the DUT wedges somewhere
   // that no bounded wait covers.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".oNo"},      32'(no),      32'h00);
      checkOutput({tag, ".oMrrReq"},  32'(mrrReq),  32'h0);
      checkOutput({tag, ".oMrrAddr"}, 32'(mrrAddr), 32'h00);
      checkOutput({tag, ".oBusy"},    32'(busy),    32'h0);
      checkOutput({tag, ".oDone"},    32'(done),    32'h0);
      checkOutput({tag, ".oPass"},    32'(pass),    32'h0);
      checkOutput({tag, ".oFailIdx"}, 32'(failIdx), 32'hFF);
      checkOutput({tag, ".oErrCnt"},  32'(errCnt),  32'h0);
   endtask

   task automatic setGolden();
      respData[4] = 8'h40;
      respData[5] = 8'h5A;
      respData[6] = 8'h08;
      respData[7] = 8'h11;
      respData[8] = 8'h22;
      respData[9] = 8'h00;
      for (int i = 0; i < 10; i++) begin
         ackDly[i]   = 2;
         respMode[i] = 0;
      end
   endtask

   // Plays the engine for one read entry. Mode 0: ack, then valid one cycle
   // later. Mode 1: ack and valid together. Mode 2: ack only, no data ever.
   task automatic applyStimulus(input int idx);
      int waited = 0;
      while (mrrReq !== 1'b1 && waited < 2000) begin
         tick();
         waited++;
      end
      checkOutput($sformatf("reqSeen[%0d]", idx), 32'(mrrReq), 32'h1);
      if (mrrReq !== 1'b1) return;
      checkOutput($sformatf("oNo[%0d]", idx), 32'(no), 32'(idx));
      checkOutput($sformatf("mrrAddr[%0d]", idx), 32'(mrrAddr), 32'(tableAddr(idx)));
      checkOutput($sformatf("busy[%0d]", idx), 32'(busy), 32'h1);
      for (int c = 0; c < ackDly[idx]; c++) begin
         tick();
         checkOutput($sformatf("reqHeld[%0d]", idx), 32'(mrrReq), 32'h1);
         checkOutput($sformatf("addrHeld[%0d]", idx), 32'(mrrAddr), 32'(tableAddr(idx)));
      end
      case (respMode[idx])
         1: begin
            mrrAck   = 1'b1;
            mrrValid = 1'b1;
            mrrData  = respData[idx];
            tick();
            mrrAck   = 1'b0;
            mrrValid = 1'b0;
            checkOutput($sformatf("reqDropAV[%0d]", idx), 32'(mrrReq), 32'h0);
         end
         2: begin
            mrrAck = 1'b1;
            tick();
            mrrAck = 1'b0;
            checkOutput($sformatf("reqDropTmo[%0d]", idx), 32'(mrrReq), 32'h0);
         end
         default: begin
            mrrAck = 1'b1;
            tick();
            mrrAck = 1'b0;
            checkOutput($sformatf("reqDrop[%0d]", idx), 32'(mrrReq), 32'h0);
            mrrValid = 1'b1;
            mrrData  = respData[idx];
            tick();
            mrrValid = 1'b0;
         end
      endcase
   endtask

   task automatic runSequence(input string tag, input logic expPass,
                              input logic [7:0] expFail, input logic [3:0] expErr,
                              input bit busyStart);
      int w = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int idx = 4; idx < 10; idx++) begin
         applyStimulus(idx);
         if (busyStart && idx == 5) begin
            start = 1'b1;
            tick();
            start = 1'b0;
         end
      end
      while (done !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      checkOutput({tag, ".doneSeen"}, 32'(done),    32'h1);
      checkOutput({tag, ".pass"},     32'(pass),    32'(expPass));
      checkOutput({tag, ".failIdx"},  32'(failIdx), 32'(expFail));
      checkOutput({tag, ".errCnt"},   32'(errCnt),  32'(expErr));
      checkOutput({tag, ".busyLow"},  32'(busy),    32'h0);
      tick();
      checkOutput({tag, ".donePulse"}, 32'(done),    32'h0);
      checkOutput({tag, ".passHeld"},  32'(pass),    32'(expPass));
      checkOutput({tag, ".failHeld"},  32'(failIdx), 32'(expFail));
      checkOutput({tag, ".errHeld"},   32'(errCnt),  32'(expErr));
      tick();
   endtask

   // Directed sequence: reset, golden run, mask cases, mismatches, timeout,
   // handshake corners, start-while-busy and a mid-run reset abort.
   initial begin
      rstN     = 1'b0;
      start    = 1'b0;
      mrrAck   = 1'b0;
      mrrValid = 1'b0;
      mrrData  = 8'h00;
      setGolden();
      @(negedge clk);
      tick();
      tick();
      checkResetValues("reset");
      rstN = 1'b1;
      tick();

      $display("[TB] golden run");
      setGolden();
      runSequence("golden", 1'b1, 8'hFF, 4'd0, 1'b0);

      $display("[TB] MR8 reserved bits set");
      setGolden();
      respData[9] = 8'h30;
      runSequence("mr8Mask", 1'b1, 8'hFF, 4'd0, 1'b0);

      $display("[TB] MR8 OP0 wrong");
      setGolden();
      respData[9] = 8'h01;
      runSequence("mr8Bad", 1'b0, 8'h09, 4'd1, 1'b0);

      $display("[TB] MR4 and MR0 wrong");
      setGolden();
      respData[4] = 8'h47;
      respData[6] = 8'h28;
      runSequence("mismatch", 1'b0, 8'h04, 4'd2, 1'b0);

      $display("[TB] no read data for index 5");
      setGolden();
      respMode[5] = 2;
      runSequence("timeout", 1'b0, 8'h05, 4'd1, 1'b0);

      $display("[TB] slow ack, ack+valid together, start while busy");
      setGolden();
      ackDly[4]   = 10;
      respMode[6] = 1;
      runSequence("handshake", 1'b1, 8'hFF, 4'd0, 1'b1);

      $display("[TB] reset during WAIT");
      setGolden();
      respMode[4] = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      applyStimulus(4);
      checkOutput("abort.busyBefore", 32'(busy), 32'h1);
      rstN = 1'b0;
      tick();
      checkResetValues("abort");
      tick();
      rstN = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checkOutput("abort.noDone", 32'(done), 32'h0);
      end
      checkOutput("abort.idle", 32'(busy), 32'h0);

      $display("[TB] clean run after abort");
      setGolden();
      runSequence("rerun", 1'b1, 8'hFF, 4'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
